// File: rtl/mem_rd_fetch.sv
// Read-only fetch engine: streams num_words memory words starting at
// base_addr into a small FIFO and presents them on a valid/ready stream.
// The memory has a fixed two-edge read latency and cannot stall, so reads
// are only issued when the FIFO is guaranteed to have room for them.
module mem_rd_fetch #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [15:0]      num_words,
    output logic             busy,
    output logic             done,
    output logic             mem_write_en,
    output logic [31:0]      mem_addr,
    input  logic [WIDTH-1:0] mem_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW+1:0] DEPTH_L = (AW+2)'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t           state;
    logic [31:0]      addr_cnt;
    logic [15:0]      issue_cnt;
    logic [15:0]      deliver_cnt;
    logic             pend0;
    logic             pend1;

    logic [AW:0]      count;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] fifo_mem [DEPTH];

    logic [AW+1:0]    occ;
    logic             issue;
    logic             push;
    logic             pop;

    // Words stored plus reads still in the memory pipeline.
    assign occ   = {1'b0, count} + (AW+2)'(pend0) + (AW+2)'(pend1);
    assign issue = (state == FETCH) && (issue_cnt != 16'd0) && (occ < DEPTH_L);
    // A read lands in the FIFO two edges after it was issued.
    assign push  = pend1;
    assign pop   = out_valid && out_ready;

    assign mem_write_en = 1'b0;
    assign out_valid    = (count != '0);
    assign out_data     = fifo_mem[rd_ptr];
    assign out_last     = out_valid && (deliver_cnt == 16'd1);

    // Control FSM, address/word counters and the read-pending pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_addr    <= 32'd0;
            addr_cnt    <= 32'd0;
            issue_cnt   <= 16'd0;
            deliver_cnt <= 16'd0;
            pend0       <= 1'b0;
            pend1       <= 1'b0;
        end else begin
            done  <= 1'b0;
            pend0 <= issue;
            pend1 <= pend0;
            if (issue) begin
                mem_addr  <= addr_cnt;
                addr_cnt  <= addr_cnt + 32'd1;
                issue_cnt <= issue_cnt - 16'd1;
            end
            if (pop) begin
                deliver_cnt <= deliver_cnt - 16'd1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_cnt    <= base_addr;
                        issue_cnt   <= num_words;
                        deliver_cnt <= num_words;
                        if (num_words == 16'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= FETCH;
                            busy  <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (issue && (issue_cnt == 16'd1)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && (deliver_cnt == 16'd1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; push and pop may coincide, even when full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_data;
        end
    end

endmodule

// File: tb/tb_mem_rd_fetch.sv
// Self-checking bench for mem_rd_fetch: a registered memory model returns a
// pattern derived from the address, and a scoreboard of expected stream
// words is filled when each transfer is launched and drained by a monitor.
`timescale 1ns/1ps
module tb_mem_rd_fetch;

    localparam int WIDTH = 64;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [31:0]      base_addr;
    logic [15:0]      num_words;
    logic             busy;
    logic             done;
    logic             mem_write_en;
    logic [31:0]      mem_addr;
    logic [WIDTH-1:0] mem_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   acc_cnt = 0;
    int   last_hs_cyc = -10;
    logic             hold_prev = 1'b0;
    logic [WIDTH-1:0] prev_data;
    logic             prev_last;

    mem_rd_fetch #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .num_words    (num_words),
        .busy         (busy),
        .done         (done),
        .mem_write_en (mem_write_en),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [WIDTH-1:0] pattern(input logic [31:0] a);
        return {a ^ 32'hDEAD_BEEF, a};
    endfunction

    // Synchronous memory: one cycle from sampling mem_addr to data.
    always @(posedge clk) mem_data <= pattern(mem_addr);

    // Stream monitor: compares every accepted word with the scoreboard head
    // and checks that a stalled word is held steady.
    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_prev) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
                    failures++;
                    $display("FAIL hold_stable: got valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                             out_valid, out_data, out_last, prev_data, prev_last);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_word: got data=%h last=%b, required no word", out_data, out_last);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (out_data !== e.data || out_last !== e.last) begin
                        failures++;
                        $display("FAIL stream_word: got data=%h last=%b, required data=%h last=%b",
                                 out_data, out_last, e.data, e.last);
                    end else begin
                        $display("word data=%h last=%b ok", out_data, out_last);
                    end
                end
                acc_cnt++;
                last_hs_cyc = cyc;
            end
            hold_prev = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
        end else begin
            hold_prev = 1'b0;
        end
    end

    // Drive start for one edge and record the words this transfer must yield.
    task automatic launch(input logic [31:0] b, input logic [15:0] n);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = b;
        num_words = n;
        for (int i = 0; i < int'(n); i++) begin
            exp_t e;
            e.data = pattern(b + 32'(i));
            e.last = (i == int'(n) - 1);
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for the done pulse; optionally check it follows the last handshake.
    task automatic wait_done(input int budget, input bit check_lat);
        bit found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL done_timeout: got no done within %0d cycles, required done", budget);
        end else begin
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL busy_at_done: got %b, required 0", busy);
            end
            if (check_lat) begin
                checks++;
                if (cyc != last_hs_cyc + 1) begin
                    failures++;
                    $display("FAIL done_latency: got cycle %0d, required %0d", cyc, last_hs_cyc + 1);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL words_left: got %0d undelivered, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, out_valid, out_last, mem_write_en} !== 5'b0 || mem_addr !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b valid=%b last=%b we=%b addr=%h, required all 0",
                     busy, done, out_valid, out_last, mem_write_en, mem_addr);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        launch(32'h10, 16'd16);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy: got busy=%b valid=%b, required busy=1 valid=0", busy, out_valid);
        end
        // Issue at edge 1, memory register at edge 2, FIFO write at edge 3.
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            checks++;
            if (mem_addr !== 32'h10 + 32'(i - 1)) begin
                failures++;
                $display("FAIL basic_addr: got %h, required %h", mem_addr, 32'h10 + 32'(i - 1));
            end
            if (i == 2 || i == 3) begin
                checks++;
                if (out_valid !== (i == 3)) begin
                    failures++;
                    $display("FAIL basic_first_valid: edge %0d got %b, required %b", i, out_valid, (i == 3));
                end
            end
        end
        wait_done(50, 1'b1);
        $display("test_basic done");
    endtask

    task automatic test_stall();
        int acc0;
        logic [31:0] addr_mid;
        bit reached = 1'b0;
        acc0 = acc_cnt;
        launch(32'h100, 16'd32);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (acc_cnt - acc0 >= 8) begin
                reached = 1'b1;
                break;
            end
        end
        checks++;
        if (!reached) begin
            failures++;
            $display("FAIL stall_progress: got %0d words, required 8", acc_cnt - acc0);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (6) @(negedge clk);
        addr_mid = mem_addr;
        repeat (4) @(negedge clk);
        checks++;
        if (mem_addr !== addr_mid) begin
            failures++;
            $display("FAIL stall_issue_stops: got %h, required %h", mem_addr, addr_mid);
        end
        checks++;
        if (int'(mem_addr - 32'h100) + 1 - (acc_cnt - acc0) != DEPTH) begin
            failures++;
            $display("FAIL stall_outstanding: got %0d, required %0d",
                     int'(mem_addr - 32'h100) + 1 - (acc_cnt - acc0), DEPTH);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done(100, 1'b1);
        checks++;
        if (acc_cnt - acc0 != 32) begin
            failures++;
            $display("FAIL stall_count: got %0d, required 32", acc_cnt - acc0);
        end
        $display("test_stall done");
    endtask

    task automatic test_wrap();
        logic [31:0] exp_addr [4];
        exp_addr[0] = 32'hFFFF_FFFE;
        exp_addr[1] = 32'hFFFF_FFFF;
        exp_addr[2] = 32'h0000_0000;
        exp_addr[3] = 32'h0000_0001;
        launch(32'hFFFF_FFFE, 16'd4);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (mem_addr !== exp_addr[i]) begin
                failures++;
                $display("FAIL wrap_addr: got %h, required %h", mem_addr, exp_addr[i]);
            end
        end
        wait_done(30, 1'b1);
        $display("test_wrap done");
    endtask

    task automatic test_zero();
        logic [31:0] addr0;
        int acc0;
        addr0 = mem_addr;
        acc0 = acc_cnt;
        launch(32'h500, 16'd0);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_done: got done=%b busy=%b, required done=1 busy=0", done, busy);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || mem_addr !== addr0) begin
                failures++;
                $display("FAIL zero_quiet: got done=%b busy=%b valid=%b addr=%h, required 0 0 0 %h",
                         done, busy, out_valid, mem_addr, addr0);
            end
        end
        checks++;
        if (acc_cnt != acc0) begin
            failures++;
            $display("FAIL zero_words: got %0d, required 0", acc_cnt - acc0);
        end
        $display("test_zero done");
    endtask

    task automatic test_busy_start();
        int acc0;
        acc0 = acc_cnt;
        launch(32'h200, 16'd8);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = 32'h300;
        num_words = 16'd5;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(50, 1'b1);
        // Present start again during the DONE cycle; it must also be ignored.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL ignored_start: got busy=%b valid=%b, required 0 0", busy, out_valid);
            end
        end
        checks++;
        if (acc_cnt - acc0 != 8) begin
            failures++;
            $display("FAIL busy_start_count: got %0d, required 8", acc_cnt - acc0);
        end
        $display("test_busy_start done");
    endtask

    task automatic test_reset_mid();
        int acc0;
        bit reached = 1'b0;
        acc0 = acc_cnt;
        launch(32'h80, 16'd8);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (acc_cnt - acc0 >= 3) begin
                reached = 1'b1;
                break;
            end
        end
        checks++;
        if (!reached) begin
            failures++;
            $display("FAIL mid_progress: got %0d words, required 3", acc_cnt - acc0);
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, out_valid, out_last} !== 4'b0 || mem_addr !== 32'd0) begin
            failures++;
            $display("FAIL mid_reset_clear: got busy=%b done=%b valid=%b last=%b addr=%h, required all 0",
                     busy, done, out_valid, out_last, mem_addr);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        acc0 = acc_cnt;
        launch(32'h40, 16'd2);
        wait_done(30, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (acc_cnt - acc0 != 2) begin
            failures++;
            $display("FAIL post_reset_count: got %0d, required 2", acc_cnt - acc0);
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        start = 1'b0;
        base_addr = 32'd0;
        num_words = 16'd0;
        out_ready = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_zero();
        test_busy_start();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
